mcycle_ctrl: RTL
================

Name: mcycle_ctrl

Overview:
Multi-cycle control FSM that drives the MDPath datapath. It sits directly upstream of MDPath and consumes the latched instruction (Inst) and MIO_ready. It sequences the IF, ID, EX, MEM and WB steps and emits every datapath control signal each cycle, plus the memory-request strobes to the MIO bus.

Parameters:
ST_W, 4, state register width (16 encodings, all used)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high; forces state IF
Inst  input  32  instruction register contents from MDPath
MIO_ready  input  1  memory/IO transaction complete this cycle
IorD  output  1  0 = PC addresses memory, 1 = ALUOut addresses memory
IRWrite  output  1  load IR (and MDR) from data2CPU
RegDst  output  2  00 rt, 01 rd, 10 r31
RegWrite  output  1  register file write enable
MemtoReg  output  2  00 ALUOut, 01 MDR, 10 {imm,16'b0}, 11 PC
ALUSrcA  output  1  0 PC, 1 reg A
ALUSrcB  output  2  00 reg B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
PCSource  output  2  00 ALU result, 01 ALUOut, 10 jump target, 11 reg A
PCWrite  output  1  unconditional PC write
PCWriteCond  output  1  conditional PC write
Branch  output  1  1 = branch on zero (beq), 0 = branch on !zero (bne)
ALU_operation  output  3  000 and, 001 or, 010 add, 011 xor, 100 nor, 110 sub, 111 slt
MemRead  output  1  memory read request
mem_w  output  1  memory write request
CPU_MIO  output  1  MemRead | mem_w
state  output  4  current state, for debug/display

Behaviour:
- State codes: 0 IF, 1 ID, 2 MEM_ADR, 3 MEM_RD, 4 LW_WB, 5 MEM_WR, 6 R_EXE, 7 R_WB, 8 BEQ, 9 BNE, 10 J, 11 I_EXE, 12 I_WB, 13 LUI_WB, 14 JAL, 15 JR.
- Outputs are Moore-decoded from the state. Exceptions: IRWrite and PCWrite in IF are ANDed with MIO_ready, and ALU_operation in R_EXE/I_EXE is decoded from Inst.
- Unlisted outputs are 0 in each state.
- Reset:
  - Asynchronous reset sets state=IF.
  - While reset=1, IRWrite, PCWrite, PCWriteCond, RegWrite, MemRead, mem_w and CPU_MIO are forced 0.
  - Reset mid-instruction abandons that instruction; there are no partial writes after reset asserts.
- IF: ALUSrcB=01, ALU=010, MemRead=1.
  - If MIO_ready=1: IRWrite=1, PCWrite=1, go to ID.
  - If MIO_ready=0: hold IF with IRWrite=PCWrite=0.
- ID: ALUSrcB=11, ALU=010. Next state decoded from Inst[31:26]:
  - 100011/101011 -> MEM_ADR
  - 000000 -> R_EXE, or JR if funct=001000
  - 000100 -> BEQ; 000101 -> BNE
  - 000010 -> J; 000011 -> JAL
  - 001000/001100/001101/001110/001010 -> I_EXE
  - 001111 -> LUI_WB
  - any other opcode -> IF (treated as nop)
- MEM_ADR: ALUSrcA=1, ALUSrcB=10, ALU=010. Next state MEM_RD for lw, MEM_WR for sw.
- MEM_RD: IorD=1, MemRead=1. Stay while MIO_ready=0; IRWrite stays 0 (MDR is loaded by the datapath). Go to LW_WB when MIO_ready=1.
- LW_WB: RegDst=00, RegWrite=1, MemtoReg=01, then IF.
- MEM_WR: IorD=1, mem_w=1. Hold while MIO_ready=0, then IF.
- R_EXE: ALUSrcA=1, ALUSrcB=00, then R_WB. ALU from funct:
  - 100000 add -> 010
  - 100010 sub -> 110
  - 100100 and -> 000
  - 100101 or -> 001
  - 100110 xor -> 011
  - 100111 nor -> 100
  - 101010 slt -> 111
  - other funct -> 010
- R_WB: RegDst=01, RegWrite=1, MemtoReg=00, then IF.
- BEQ: ALUSrcA=1, ALUSrcB=00, ALU=110, PCSource=01, PCWriteCond=1, Branch=1, then IF.
- BNE: same as BEQ but Branch=0.
- J: PCSource=10, PCWrite=1, then IF.
- JAL: one state, RegDst=10, MemtoReg=11, RegWrite=1, PCSource=10, PCWrite=1. The PC already holds PC+4, so r31 receives the return address. Then IF.
- JR: PCSource=11, PCWrite=1, then IF.
- I_EXE: ALUSrcA=1, ALUSrcB=10, then I_WB. ALU by opcode: addi 010, andi 000, ori 001, xori 011, slti 111.
- I_WB: RegDst=00, RegWrite=1, MemtoReg=00, then IF.
- LUI_WB: RegDst=00, RegWrite=1, MemtoReg=10, then IF.
- Cycles per instruction with MIO_ready=1:
  - lw 5; R-type 4; sw 4; I-type 4
  - beq/bne/j/jal/jr/lui 3
  - Each MIO_ready=0 cycle in IF, MEM_RD or MEM_WR adds one cycle.

Test Plan:
- Reset held 40ns, then Inst=0x00000820 (add r1,r0,r0) -> states 0,1,6,7,0. IF control word = 18'b010000000100100010. R_WB has RegDst=01, RegWrite=1.
- Inst=0x8C220000 (lw), MIO_ready=0 for 2 cycles in MEM_RD -> state held at 3 with IorD=1, MemRead=1 for 3 cycles total. Then LW_WB with MemtoReg=01, RegWrite=1. 7 cycles total.
- Inst=0x10410002 (beq) -> BEQ word 18'b000000010001011110. Inst=0x14410002 (bne) -> identical except Branch=0.
- Inst=0x0C000008 (jal) -> states 0,1,14. In state 14: RegDst=10, MemtoReg=11, RegWrite=1, PCSource=10, PCWrite=1.
- Inst=0xFC000000 (illegal opcode) -> 0,1,0 with no RegWrite/mem_w/PCWriteCond pulse. Inst=0xAC220000 (sw) with reset asserted in MEM_WR -> mem_w drops to 0 immediately and state=0.
- MIO_ready=0 during IF -> state stays 0 with IRWrite=PCWrite=0. When it rises, both pulse for exactly one cycle.

Source files
------------

// File: rtl/mcycle_ctrl_if.sv
// Control bundle between mcycle_ctrl and the MDPath datapath / MIO bus.
// master = controller side, slave = datapath side.
interface mcycle_ctrl_if #(parameter int ST_W = 4);
  logic [31:0]     Inst;
  logic            MIO_ready;
  logic            IorD;
  logic            IRWrite;
  logic [1:0]      RegDst;
  logic            RegWrite;
  logic [1:0]      MemtoReg;
  logic            ALUSrcA;
  logic [1:0]      ALUSrcB;
  logic [1:0]      PCSource;
  logic            PCWrite;
  logic            PCWriteCond;
  logic            Branch;
  logic [2:0]      ALU_operation;
  logic            MemRead;
  logic            mem_w;
  logic            CPU_MIO;
  logic [ST_W-1:0] state;

  modport master (
    input  Inst, MIO_ready,
    output IorD, IRWrite, RegDst, RegWrite, MemtoReg, ALUSrcA, ALUSrcB,
           PCSource, PCWrite, PCWriteCond, Branch, ALU_operation,
           MemRead, mem_w, CPU_MIO, state
  );
  modport slave (
    output Inst, MIO_ready,
    input  IorD, IRWrite, RegDst, RegWrite, MemtoReg, ALUSrcA, ALUSrcB,
           PCSource, PCWrite, PCWriteCond, Branch, ALU_operation,
           MemRead, mem_w, CPU_MIO, state
  );
endinterface

// File: rtl/mcycle_ctrl.sv
// Multi-cycle MIPS control FSM: sequences IF/ID/EX/MEM/WB and Moore-decodes
// every MDPath control signal plus the MIO request strobes.
module mcycle_ctrl #(
  parameter int ST_W = 4
) (
  input  logic          clk,
  input  logic          reset,
  mcycle_ctrl_if.master bus
);
  typedef enum logic [ST_W-1:0] {
    S_IF = 4'd0,  S_ID = 4'd1,  S_MEM_ADR = 4'd2, S_MEM_RD = 4'd3,
    S_LW_WB = 4'd4, S_MEM_WR = 4'd5, S_R_EXE = 4'd6, S_R_WB = 4'd7,
    S_BEQ = 4'd8, S_BNE = 4'd9, S_J = 4'd10, S_I_EXE = 4'd11,
    S_I_WB = 4'd12, S_LUI_WB = 4'd13, S_JAL = 4'd14, S_JR = 4'd15
  } state_t;

  state_t     r_state, w_nxt;
  logic [5:0] w_op, w_fn;
  logic       w_iord, w_irw, w_rw, w_alua, w_pcw, w_pcwc, w_br, w_mrd, w_mwr;
  logic [1:0] w_rdst, w_m2r, w_alub, w_pcs;
  logic [2:0] w_alu;

  assign w_op = bus.Inst[31:26];
  assign w_fn = bus.Inst[5:0];

  function automatic logic [2:0] f_rfunc(input logic [5:0] fn);
    case (fn)
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b100110: return 3'b011;
      6'b100111: return 3'b100;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  function automatic logic [2:0] f_iop(input logic [5:0] op);
    case (op)
      6'b001100: return 3'b000;
      6'b001101: return 3'b001;
      6'b001110: return 3'b011;
      6'b001010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IF;
    else       r_state <= w_nxt;
  end

  always_comb begin
    w_nxt  = r_state;
    w_iord = 1'b0; w_irw  = 1'b0; w_rw  = 1'b0; w_alua = 1'b0;
    w_pcw  = 1'b0; w_pcwc = 1'b0; w_br  = 1'b0; w_mrd  = 1'b0; w_mwr = 1'b0;
    w_rdst = 2'b00; w_m2r = 2'b00; w_alub = 2'b00; w_pcs = 2'b00;
    w_alu  = 3'b000;
    case (r_state)
      S_IF: begin
        w_alub = 2'b01; w_alu = 3'b010; w_mrd = 1'b1;
        if (bus.MIO_ready) begin
          w_irw = 1'b1; w_pcw = 1'b1; w_nxt = S_ID;
        end
      end
      S_ID: begin
        w_alub = 2'b11; w_alu = 3'b010;
        case (w_op)
          6'b100011, 6'b101011: w_nxt = S_MEM_ADR;
          6'b000000: w_nxt = (w_fn == 6'b001000) ? S_JR : S_R_EXE;
          6'b000100: w_nxt = S_BEQ;
          6'b000101: w_nxt = S_BNE;
          6'b000010: w_nxt = S_J;
          6'b000011: w_nxt = S_JAL;
          6'b001000, 6'b001100, 6'b001101, 6'b001110, 6'b001010: w_nxt = S_I_EXE;
          6'b001111: w_nxt = S_LUI_WB;
          default:   w_nxt = S_IF;
        endcase
      end
      S_MEM_ADR: begin
        w_alua = 1'b1; w_alub = 2'b10; w_alu = 3'b010;
        w_nxt  = (w_op == 6'b100011) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        w_iord = 1'b1; w_mrd = 1'b1;
        if (bus.MIO_ready) w_nxt = S_LW_WB;
      end
      S_LW_WB: begin
        w_rw = 1'b1; w_m2r = 2'b01; w_nxt = S_IF;
      end
      S_MEM_WR: begin
        w_iord = 1'b1; w_mwr = 1'b1;
        if (bus.MIO_ready) w_nxt = S_IF;
      end
      S_R_EXE: begin
        w_alua = 1'b1; w_alu = f_rfunc(w_fn); w_nxt = S_R_WB;
      end
      S_R_WB: begin
        w_rdst = 2'b01; w_rw = 1'b1; w_nxt = S_IF;
      end
      S_BEQ, S_BNE: begin
        w_alua = 1'b1; w_alu = 3'b110; w_pcs = 2'b01; w_pcwc = 1'b1;
        w_br   = (r_state == S_BEQ); w_nxt = S_IF;
      end
      S_J: begin
        w_pcs = 2'b10; w_pcw = 1'b1; w_nxt = S_IF;
      end
      S_I_EXE: begin
        w_alua = 1'b1; w_alub = 2'b10; w_alu = f_iop(w_op); w_nxt = S_I_WB;
      end
      S_I_WB: begin
        w_rw = 1'b1; w_nxt = S_IF;
      end
      S_LUI_WB: begin
        w_rw = 1'b1; w_m2r = 2'b10; w_nxt = S_IF;
      end
      // PC already holds PC+4 here, so r31 gets the return address directly
      S_JAL: begin
        w_rdst = 2'b10; w_m2r = 2'b11; w_rw = 1'b1; w_pcs = 2'b10; w_pcw = 1'b1;
        w_nxt  = S_IF;
      end
      S_JR: begin
        w_pcs = 2'b11; w_pcw = 1'b1; w_nxt = S_IF;
      end
    endcase
  end

  // Write/request strobes are killed combinationally so reset never leaks a write
  assign bus.IRWrite       = w_irw  & ~reset;
  assign bus.PCWrite       = w_pcw  & ~reset;
  assign bus.PCWriteCond   = w_pcwc & ~reset;
  assign bus.RegWrite      = w_rw   & ~reset;
  assign bus.MemRead       = w_mrd  & ~reset;
  assign bus.mem_w         = w_mwr  & ~reset;
  assign bus.CPU_MIO       = (w_mrd | w_mwr) & ~reset;
  assign bus.IorD          = w_iord;
  assign bus.RegDst        = w_rdst;
  assign bus.MemtoReg      = w_m2r;
  assign bus.ALUSrcA       = w_alua;
  assign bus.ALUSrcB       = w_alub;
  assign bus.PCSource      = w_pcs;
  assign bus.Branch        = w_br;
  assign bus.ALU_operation = w_alu;
  assign bus.state         = r_state;
endmodule
